pipe_pc: RTL and testbench
==========================

Name: pipe_PC

Overview:
- Program-counter stage directly upstream of the instruction-fetch stage. Holds the architectural fetch PC and drives it into pipe_IF each cycle.
- Selects the next PC from these sources: sequential PC+4, branch target, jump target, exception vector, or a buffered (pending) redirect.
- Supports pipeline stall. A redirect that arrives during a stall is buffered until the stall clears.
- Emits a flush pulse that squashes the wrong-path instruction in the IF/ID register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- EXC_VECTOR, 32'h0000_0008, exception handler entry address.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- stall  input  1  hold PC (hazard from ID/EX).
- br_taken  input  1  branch resolved taken this cycle.
- br_target  input  32  branch target address.
- jmp  input  1  jump this cycle.
- jmp_target  input  32  jump target address.
- exc  input  1  exception request.
- pc  output  32  current fetch PC, registered; feeds pipe_IF.
- flush  output  1  combinational; high in a cycle in which a redirect is applied.
- pend_valid  output  1  registered; pending-redirect buffer occupied.

Behaviour:
- Reset (clk edge with rst=1): pc<=RESET_PC, pend_valid<=0, pending address<=0. rst overrides every other input, including a pending redirect or an exception. flush=0 while rst=1.
- Target alignment: br_target, jmp_target and EXC_VECTOR have bits[1:0] forced to 0 before use.
- Sequential path: seq = pc + 32'd4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Source priority, when stall=0:
  1. exc: pc<=EXC_VECTOR. Any pending entry is discarded (pend_valid<=0).
  2. pend_valid: pc<=pending address; pend_valid<=0. Incoming br_taken/jmp are ignored this cycle, because the pending entry belongs to the older instruction.
  3. br_taken: pc<=br_target.
  4. jmp: pc<=jmp_target.
  5. Otherwise: pc<=seq.
- flush is high whenever case 1–4 applies with stall=0 and rst=0. It is low otherwise. Latency: redirect at cycle t gives pc=target at t+1, and flush is high during t.
- Stall (stall=1, rst=0):
  - pc holds its value and flush=0.
  - exc=1: pending<=EXC_VECTOR and pend_valid<=1. This overwrites any existing entry.
  - else br_taken=1 and pend_valid=0: pending<=br_target and pend_valid<=1.
  - else jmp=1 and pend_valid=0: pending<=jmp_target and pend_valid<=1.
  - A br/jmp that arrives while pend_valid=1 is dropped; the existing entry is kept.
- Buffer depth is 1; it never overflows (rules above).
- Simultaneous br_taken and jmp in the same cycle: the branch wins.
- No combinational path from stall to pc. The pc and pend_valid outputs are flop outputs only.

Test Plan:
- Reset → sequential fetch:
  - Stimulus: rst=1 for 2 cycles, then release with all controls at 0.
  - Required: pc=0 while in reset, then 0x4, 0x8, 0xC on successive cycles; flush=0 throughout.
- Stall hold:
  - Stimulus: at pc=0x10, stall=1 for 3 cycles.
  - Required: pc stays 0x10 for 3 cycles, then 0x14; pend_valid=0.
- Branch and jump redirect:
  - Stimulus: at pc=0x20, br_taken=1 with br_target=0x103, and jmp=1 with jmp_target=0x400 in the same cycle.
  - Required: flush=1 in that cycle; next pc=0x100, then 0x104.
- Redirect during stall:
  - Stimulus: stall=1 with jmp=1, jmp_target=0x80 for one cycle; next cycle stall=1 with br_taken=1, br_target=0x90; then stall=0 with br_taken=1, br_target=0x200.
  - Required: pend_valid=1 after the first stalled cycle and holds 0x80 (the 0x90 request is dropped). In the stall=0 cycle flush=1, and next pc=0x80 (not 0x200); pend_valid=0.
- Exception priority:
  - Stimulus: with pend_valid=1 (pending 0x80) and stall=1, assert exc=1; then stall=0.
  - Required: pending is overwritten with 0x8 and pc becomes 0x8. Also, with stall=0, exc and br_taken both high must give pc=0x8.
- Wrap and reset mid-operation:
  - Stimulus 1: force pc=0xFFFF_FFFC via jmp_target, then run sequentially.
  - Required: next pc=0x0.
  - Stimulus 2: with pend_valid=1, assert rst=1 alongside stall=0.
  - Required: pc=RESET_PC and pend_valid=0 on the next edge; the pending target is never fetched.

Source files
------------

// File: rtl/pipe_pc.sv
// Fetch program counter with next-PC select,
// stall hold and a one-deep pending redirect.
module pipe_pc #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        exc,
  output logic [31:0] pc,
  output logic        flush,
  output logic        pend_valid
);

  logic [31:0] pend_addr;
  logic [31:0] br_al;
  logic [31:0] jmp_al;
  logic [31:0] exc_al;
  logic [31:0] seq;
  logic [31:0] pc_nxt;
  logic [31:0] pend_nxt;
  logic        pv_nxt;

  assign br_al  = {br_target[31:2], 2'b00};
  assign jmp_al = {jmp_target[31:2], 2'b00};
  assign exc_al = {EXC_VECTOR[31:2], 2'b00};
  assign seq    = pc + 32'd4;

  // Next-PC select, pending-buffer update and flush
  always_comb begin
    pc_nxt   = pc;
    pend_nxt = pend_addr;
    pv_nxt   = pend_valid;
    flush    = 1'b0;
    if (rst) begin
      pc_nxt   = RESET_PC;
      pend_nxt = 32'd0;
      pv_nxt   = 1'b0;
    end else if (stall) begin
      if (exc) begin
        pend_nxt = exc_al;
        pv_nxt   = 1'b1;
      end else if (br_taken && !pend_valid) begin
        pend_nxt = br_al;
        pv_nxt   = 1'b1;
      end else if (jmp && !pend_valid) begin
        pend_nxt = jmp_al;
        pv_nxt   = 1'b1;
      end
    end else if (exc) begin
      pc_nxt = exc_al;
      pv_nxt = 1'b0;
      flush  = 1'b1;
    end else if (pend_valid) begin
      pc_nxt = pend_addr;
      pv_nxt = 1'b0;
      flush  = 1'b1;
    end else if (br_taken) begin
      pc_nxt = br_al;
      flush  = 1'b1;
    end else if (jmp) begin
      pc_nxt = jmp_al;
      flush  = 1'b1;
    end else begin
      pc_nxt = seq;
    end
  end

  // PC and pending-redirect registers
  always_ff @(posedge clk) begin
    pc         <= pc_nxt;
    pend_addr  <= pend_nxt;
    pend_valid <= pv_nxt;
  end

endmodule

// File: tb/tb_pipe_pc.sv
// Scoreboard bench for pipe_pc: directed vectors
// push expected per-cycle outputs, a monitor checks.
module tb_pipe_pc;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        exc;
  logic [31:0] pc;
  logic        flush;
  logic        pend_valid;

  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic        pv;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;
  bit   done   = 0;

  pipe_pc #(
    .RESET_PC  (32'h0000_0000),
    .EXC_VECTOR(32'h0000_0008)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jmp       (jmp),
    .jmp_target(jmp_target),
    .exc       (exc),
    .pc        (pc),
    .flush     (flush),
    .pend_valid(pend_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and record the outputs
  // expected during that cycle (pc is pre-edge state).
  task automatic cyc(
    input logic        i_rst,
    input logic        i_stall,
    input logic        i_br,
    input logic [31:0] i_bt,
    input logic        i_jmp,
    input logic [31:0] i_jt,
    input logic        i_exc,
    input logic [31:0] e_pc,
    input logic        e_fl,
    input logic        e_pv
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst        = i_rst;
    stall      = i_stall;
    br_taken   = i_br;
    br_target  = i_bt;
    jmp        = i_jmp;
    jmp_target = i_jt;
    exc        = i_exc;
    vec_id++;
    e.pc = e_pc;
    e.fl = e_fl;
    e.pv = e_pv;
    e.id = vec_id;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (pc !== e.pc) begin
          errors++;
          $display("FAIL v%0d pc got %h want %h",
                   e.id, pc, e.pc);
        end
        checks++;
        if (flush !== e.fl) begin
          errors++;
          $display("FAIL v%0d flush got %b want %b",
                   e.id, flush, e.fl);
        end
        checks++;
        if (pend_valid !== e.pv) begin
          errors++;
          $display("FAIL v%0d pend_valid got %b want %b",
                   e.id, pend_valid, e.pv);
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    stall      = 1'b0;
    br_taken   = 1'b0;
    br_target  = 32'd0;
    jmp        = 1'b0;
    jmp_target = 32'd0;
    exc        = 1'b0;
    // reset second cycle, then sequential fetch
    cyc(1,0,0,0,0,0,0, 32'h0,   0,0);
    cyc(0,0,0,0,0,0,0, 32'h0,   0,0);
    cyc(0,0,0,0,0,0,0, 32'h4,   0,0);
    cyc(0,0,0,0,0,0,0, 32'h8,   0,0);
    cyc(0,0,0,0,0,0,0, 32'hC,   0,0);
    // stall hold at 0x10
    cyc(0,1,0,0,0,0,0, 32'h10,  0,0);
    cyc(0,1,0,0,0,0,0, 32'h10,  0,0);
    cyc(0,1,0,0,0,0,0, 32'h10,  0,0);
    cyc(0,0,0,0,0,0,0, 32'h10,  0,0);
    cyc(0,0,0,0,0,0,0, 32'h14,  0,0);
    cyc(0,0,0,0,0,0,0, 32'h18,  0,0);
    cyc(0,0,0,0,0,0,0, 32'h1C,  0,0);
    // branch beats jump, target aligned
    cyc(0,0,1,32'h103,1,32'h400,0, 32'h20, 1,0);
    cyc(0,0,0,0,0,0,0, 32'h100, 0,0);
    // redirect during stall, second one dropped
    cyc(0,1,0,0,1,32'h80,0,     32'h104, 0,0);
    cyc(0,1,1,32'h90,0,0,0,     32'h104, 0,1);
    cyc(0,0,1,32'h200,0,0,0,    32'h104, 1,1);
    cyc(0,0,0,0,0,0,0,          32'h80,  0,0);
    // exception overwrites pending entry
    cyc(0,1,0,0,1,32'h80,0,     32'h84,  0,0);
    cyc(0,1,0,0,0,0,1,          32'h84,  0,1);
    cyc(0,0,0,0,0,0,0,          32'h84,  1,1);
    cyc(0,0,1,32'h300,0,0,1,    32'h8,   1,0);
    cyc(0,0,0,0,0,0,0,          32'h8,   0,0);
    // unstalled exception discards pending entry
    cyc(0,1,0,0,1,32'h50,0,     32'hC,   0,0);
    cyc(0,0,0,0,0,0,1,          32'hC,   1,1);
    cyc(0,0,0,0,0,0,0,          32'h8,   0,0);
    // wrap from 0xFFFF_FFFC
    cyc(0,0,0,0,1,32'hFFFF_FFFE,0, 32'hC, 1,0);
    cyc(0,0,0,0,0,0,0, 32'hFFFF_FFFC, 0,0);
    cyc(0,0,0,0,0,0,0,          32'h0,   0,0);
    // reset while pending entry held
    cyc(0,1,1,32'h60,0,0,0,     32'h4,   0,0);
    cyc(1,0,0,0,0,0,0,          32'h4,   0,1);
    cyc(0,0,0,0,0,0,0,          32'h0,   0,0);
    cyc(0,0,0,0,0,0,0,          32'h4,   0,0);
    // reset overrides exception
    cyc(1,0,0,0,0,0,1,          32'h8,   0,0);
    cyc(0,0,0,0,0,0,0,          32'h0,   0,0);
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0",
               exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
